robo_nav_ctrl: RTL
==================

// Module: robo_nav_ctrl
// PURPOSE
//  Navigation sequencer for the robot in the 10x20 map memory. Samples the head/left/under/barrier sensors,
//  applies a left-hand wall-following rule and issues one move command at a time to the memory block.
//  Each command uses a valid/ack handshake, then the block waits for the sensors to settle.
//  Sits in Top between the map memory (sensor source, command sink) and the external start input.
// PARAMETERS
//  SETTLE_CYCLES  1     cycles waited after a command ack before re-sampling sensors (>=1)
//  STUCK_TURNS    4     consecutive turns (no FWD/REMOVE between) that declare the robot stuck
//  MAX_STEPS      1000  accepted commands before timeout
//  STEP_W         16    width of step_count; must hold MAX_STEPS
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse; starts a run from IDLE, DONE or STUCK
//  head        in   1       1 = cell ahead blocked
//  left        in   1       1 = cell to the left blocked
//  under       in   1       1 = robot is on the exit cell
//  barrier     in   1       1 = the blocking cell ahead is removable rubble
//  cmd_valid   out  1       command present on cmd
//  cmd         out  3       1=FWD 2=TURN_L 3=TURN_R 4=REMOVE, 0 when idle
//  cmd_ack     in   1       memory accepts cmd in the cycle it is high together with cmd_valid
//  busy        out  1       high in every state except IDLE/DONE/STUCK
//  done        out  1       exit reached; held until next start
//  stuck       out  1       STUCK_TURNS limit or MAX_STEPS limit hit; held until next start
//  timeout     out  1       qualifies stuck: set only when MAX_STEPS caused it
//  step_count  out  STEP_W  number of accepted commands in the current run
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): state=IDLE. All outputs are 0. Internal flags and counters clear.
//    A reset mid-handshake drops cmd_valid immediately, with no wait for ack.
//  - States: IDLE, SAMPLE, DECIDE, ISSUE, SETTLE, DONE, STUCK.
//  - IDLE/DONE/STUCK --start--> SAMPLE. This clears done, stuck, timeout, step_count, turn_cnt and jtl.
//    start is ignored while busy.
//  - SAMPLE: register {head,left,under,barrier}. Always goes to DECIDE next.
//  - DECIDE evaluates rules in priority order on the registered sensors. jtl = "just turned left" flag.
//    1. under=1 -> DONE (done=1).
//    2. step_count==MAX_STEPS -> STUCK (stuck=1, timeout=1).
//    3. left=0 && jtl=0 -> cmd=TURN_L; set jtl.
//    4. head=0 -> cmd=FWD; clear jtl.
//    5. head=1 && barrier=1 -> cmd=REMOVE; jtl unchanged.
//    6. otherwise -> cmd=TURN_R; clear jtl.
//    Rules 3-6 lead to ISSUE.
//  - ISSUE: cmd_valid=1. cmd stays stable until the cycle with cmd_ack=1.
//    On that edge: step_count+1; TURN_L/TURN_R increment turn_cnt; FWD/REMOVE clear turn_cnt.
//    Then cmd_valid=0 and cmd=0, and the state goes to SETTLE.
//  - If turn_cnt reaches STUCK_TURNS on that edge -> STUCK (stuck=1, timeout=0) instead of SETTLE.
//  - cmd_ack while cmd_valid=0 is ignored.
//  - SETTLE: counts SETTLE_CYCLES cycles, then goes to SAMPLE.
//  - Latency: start at edge N gives SAMPLE at N+1, DECIDE at N+2, and cmd_valid high after edge N+3.
//    Ack at edge A puts SAMPLE at A+SETTLE_CYCLES+1.
//  - step_count saturates at MAX_STEPS and never wraps. turn_cnt saturates at STUCK_TURNS.
//  - If under and MAX_STEPS are met together, done wins.
// TESTING
//  1. Reset mid-ISSUE with ack held low: cmd_valid=0, cmd=0 and busy=0 the same cycle; IDLE after release.
//  2. start with head=0, left=1: FWD issued 3 cycles after start. Ack delayed 5 cycles: cmd stays stable.
//     step_count=1 after ack. Next sample occurs SETTLE_CYCLES+1 cycles after ack.
//  3. left=0 throughout, head=0: issues TURN_L, then FWD (jtl blocks a second TURN_L), then TURN_L again.
//  4. head=1, barrier=1: REMOVE issued. With barrier=0 and left=1: TURN_R. turn_cnt clears after REMOVE.
//  5. head=1, left=1, barrier=0 constant: exactly 4 TURN_R commands, then stuck=1, timeout=0, busy=0.
//  6. under=1 at first sample: done=1 with no cmd_valid ever. MAX_STEPS=3 open corridor: 3 FWD, then stuck=1, timeout=1.
//     A new start clears both and step_count.

Source files
------------

// File: rtl/robo_nav_ctrl.sv
// Left-hand wall-following navigation sequencer: samples sensors, picks one move,
// hands it to the map memory over a valid/ack handshake, then waits for sensors to settle.
module robo_nav_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned STUCK_TURNS   = 4,
    parameter int unsigned MAX_STEPS     = 1000,
    parameter int unsigned STEP_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              head,
    input  logic              left,
    input  logic              under,
    input  logic              barrier,
    output logic              cmd_valid,
    output logic [2:0]        cmd,
    input  logic              cmd_ack,
    output logic              busy,
    output logic              done,
    output logic              stuck,
    output logic              timeout,
    output logic [STEP_W-1:0] step_count
);

    localparam int unsigned TURN_W = $clog2(STUCK_TURNS + 1);
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_DECIDE, S_ISSUE, S_SETTLE, S_DONE, S_STUCK
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_FWD    = 3'd1,
        CMD_TURN_L = 3'd2,
        CMD_TURN_R = 3'd3,
        CMD_REMOVE = 3'd4
    } cmd_e;

    typedef struct packed {
        logic head;
        logic left;
        logic under;
        logic barrier;
    } sens_t;

    state_e              state_q, state_d;
    cmd_e                cmd_q, cmd_d;
    sens_t               sens_q, sens_d;
    logic                jtl_q, jtl_d;
    logic [TURN_W-1:0]   turn_q, turn_d, turn_inc;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [SET_W-1:0]    set_q, set_d;
    logic                done_q, done_d;
    logic                stuck_q, stuck_d;
    logic                timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_NONE;
            sens_q    <= '0;
            jtl_q     <= 1'b0;
            turn_q    <= '0;
            step_q    <= '0;
            set_q     <= '0;
            done_q    <= 1'b0;
            stuck_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            sens_q    <= sens_d;
            jtl_q     <= jtl_d;
            turn_q    <= turn_d;
            step_q    <= step_d;
            set_q     <= set_d;
            done_q    <= done_d;
            stuck_q   <= stuck_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        sens_d    = sens_q;
        jtl_d     = jtl_q;
        turn_d    = turn_q;
        step_d    = step_q;
        set_d     = set_q;
        done_d    = done_q;
        stuck_d   = stuck_q;
        timeout_d = timeout_q;
        turn_inc  = (turn_q == TURN_W'(STUCK_TURNS)) ? turn_q : turn_q + 1'b1;

        unique case (state_q)
            S_IDLE, S_DONE, S_STUCK: begin
                if (start) begin
                    state_d   = S_SAMPLE;
                    done_d    = 1'b0;
                    stuck_d   = 1'b0;
                    timeout_d = 1'b0;
                    step_d    = '0;
                    turn_d    = '0;
                    jtl_d     = 1'b0;
                end
            end
            S_SAMPLE: begin
                sens_d  = '{head: head, left: left, under: under, barrier: barrier};
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                state_d = S_ISSUE;
                if (sens_q.under) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (step_q == STEP_W'(MAX_STEPS)) begin
                    state_d   = S_STUCK;
                    stuck_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (!sens_q.left && !jtl_q) begin
                    cmd_d = CMD_TURN_L;
                    jtl_d = 1'b1;
                end else if (!sens_q.head) begin
                    cmd_d = CMD_FWD;
                    jtl_d = 1'b0;
                end else if (sens_q.barrier) begin
                    cmd_d = CMD_REMOVE;
                end else begin
                    cmd_d = CMD_TURN_R;
                    jtl_d = 1'b0;
                end
            end
            S_ISSUE: begin
                if (cmd_ack) begin
                    step_d  = (step_q == STEP_W'(MAX_STEPS)) ? step_q : step_q + 1'b1;
                    cmd_d   = CMD_NONE;
                    set_d   = '0;
                    state_d = S_SETTLE;
                    if (cmd_q == CMD_TURN_L || cmd_q == CMD_TURN_R) begin
                        turn_d = turn_inc;
                        // The turn that reaches the limit ends the run without settling.
                        if (turn_inc == TURN_W'(STUCK_TURNS)) begin
                            state_d   = S_STUCK;
                            stuck_d   = 1'b1;
                            timeout_d = 1'b0;
                        end
                    end else begin
                        turn_d = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (set_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_valid  = (state_q == S_ISSUE);
    assign cmd        = (state_q == S_ISSUE) ? cmd_q : CMD_NONE;
    assign busy       = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_STUCK);
    assign done       = done_q;
    assign stuck      = stuck_q;
    assign timeout    = timeout_q;
    assign step_count = step_q;

endmodule
